// File: rtl/ps2_keyevent_rx_if.sv
// Key-event stream bundle between the PS/2 receiver and its consumer.
// master: drives event_code/ext/break/valid, samples event_ready; slave: the reverse.
interface ps2_keyevent_rx_if;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;
    logic       event_valid;
    logic       event_ready;

    modport master (
        output event_code,
        output event_ext,
        output event_break,
        output event_valid,
        input  event_ready
    );

    modport slave (
        input  event_code,
        input  event_ext,
        input  event_break,
        input  event_valid,
        output event_ready
    );
endinterface

// File: rtl/ps2_keyevent_rx.sv
// PS/2 host receiver: filters the lines, frames 11-bit words, folds E0/F0 into
// flags and queues {break, ext, code} events in a fall-through FIFO.
// Ports: sys_clk/reset, PS2Clk/PS2Data pins, ev (event stream, master side),
// fifo_count (entries queued), frame_err (error pulse), overflow (sticky drop flag).
module ps2_keyevent_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          PS2Clk,
    input  logic                          PS2Data,
    ps2_keyevent_rx_if.master             ev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int FW     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- input conditioning ----------------
    // Index 0 is the clock line, index 1 the data line. Both get the same
    // lag, so data is already settled when the filtered clock falls.
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    filt;
    logic          clk_d;
    logic [FW-1:0] fcnt [2];

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            s1      <= 2'b11;
            s2      <= 2'b11;
            filt    <= 2'b11;
            clk_d   <= 1'b1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            s1    <= {PS2Data, PS2Clk};
            s2    <= s1;
            clk_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    logic fall;
    logic data_f;

    assign fall   = clk_d & ~filt[0];
    assign data_f = filt[1];

    // ---------------- frame FSM ----------------
    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_q, par_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          ext_pend, ext_n;
    logic          brk_pend, brk_n;
    logic          push_req, push_req_n;
    logic [9:0]    push_data, push_data_n;
    logic          ferr_q, ferr_n;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_q     <= 1'b0;
            to_cnt    <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            push_req  <= 1'b0;
            push_data <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            par_q     <= par_n;
            to_cnt    <= to_cnt_n;
            ext_pend  <= ext_n;
            brk_pend  <= brk_n;
            push_req  <= push_req_n;
            push_data <= push_data_n;
            ferr_q    <= ferr_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        par_n       = par_q;
        ext_n       = ext_pend;
        brk_n       = brk_pend;
        push_req_n  = 1'b0;
        push_data_n = push_data;
        ferr_n      = 1'b0;

        if (state == IDLE || fall) begin
            to_cnt_n = '0;
        end else begin
            to_cnt_n = to_cnt + TW'(1);
        end

        unique case (state)
            IDLE: begin
                if (fall && !data_f) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n   = {data_f, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = data_f;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (data_f && (^{shreg, par_q})) begin
                        if (shreg == 8'hE0) begin
                            ext_n = 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_n = 1'b1;
                        end else begin
                            push_req_n  = 1'b1;
                            push_data_n = {brk_pend, ext_pend, shreg};
                            ext_n       = 1'b0;
                            brk_n       = 1'b0;
                        end
                    end else begin
                        ferr_n = 1'b1;
                        ext_n  = 1'b0;
                        brk_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Stalled frame: abandon it silently, prefix flags untouched.
        if (state != IDLE && !fall && to_cnt == TW'(TO_CYC - 1)) begin
            state_n  = IDLE;
            to_cnt_n = '0;
        end
    end

    // ---------------- event FIFO ----------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, wp_n;
    logic [AW-1:0] rp, rp_n;
    logic [CW-1:0] count, count_n;
    logic [9:0]    head, head_n;
    logic          valid_q;
    logic          ovf_q;
    logic          full;
    logic          rd_en;
    logic          wr_en;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign rd_en = valid_q && ev.event_ready;
    assign wr_en = push_req && (!full || rd_en);

    always_comb begin
        wp_n = wr_en ? wp + AW'(1) : wp;
        rp_n = rd_en ? rp + AW'(1) : rp;
        unique case ({wr_en, rd_en})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
        // The new head may be the word being written this very cycle.
        if (wr_en && rp_n == wp) begin
            head_n = push_data;
        end else begin
            head_n = mem[rp_n];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wp] <= push_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            head    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wp      <= wp_n;
            rp      <= rp_n;
            count   <= count_n;
            valid_q <= (count_n != '0);
            if (count_n != '0) begin
                head <= head_n;
            end
            if (push_req && full && !rd_en) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ev.event_code  = head[7:0];
    assign ev.event_ext   = head[8];
    assign ev.event_break = head[9];
    assign ev.event_valid = valid_q;
    assign fifo_count     = count;
    assign frame_err      = ferr_q;
    assign overflow       = ovf_q;

endmodule
